// File: rtl/bmp_stream_writer.sv
// Serialises hsync-qualified RGB pixel pairs into a 24-bit BMP byte stream
// (header, BGR pixels, row padding) on a valid/ready byte interface.
//
// state    | meaning
// ---------+-------------------------------------------------
// S_HEADER | emit the 54 header bytes
// S_PIXELS | emit B0 G0 R0 B1 G1 R1 of the FIFO head entry
// S_PAD    | emit the zero bytes that round a row up to 4
// S_DONE   | file complete, output idle until reset
module bmp_stream_writer #(
    parameter int WIDTH      = 768,
    parameter int HEIGHT     = 512,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       hsync,
    input  logic [7:0] DATA_WRITE_R0,
    input  logic [7:0] DATA_WRITE_G0,
    input  logic [7:0] DATA_WRITE_B0,
    input  logic [7:0] DATA_WRITE_R1,
    input  logic [7:0] DATA_WRITE_G1,
    input  logic [7:0] DATA_WRITE_B1,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       overflow,
    output logic       Write_Done
);

    localparam int PAD = (4 - ((3 * WIDTH) % 4)) % 4;
    localparam int ROWB = 3 * WIDTH + PAD;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = $clog2(WIDTH / 2 + 1);
    localparam int RW = $clog2(HEIGHT + 1);
    localparam logic [31:0] IMG_SIZE  = 32'(HEIGHT * ROWB);
    localparam logic [31:0] FILE_SIZE = 32'd54 + IMG_SIZE;

    typedef enum logic [1:0] {S_HEADER, S_PIXELS, S_PAD, S_DONE} state_t;

    state_t          state_q, state_d;
    logic            run_q;
    logic [5:0]      hdr_q, hdr_d;
    logic [2:0]      byte_q, byte_d;
    logic [PW-1:0]   pair_q, pair_d;
    logic [RW-1:0]   row_q, row_d;
    logic [1:0]      pad_q, pad_d;
    logic            row_end;

    logic [47:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     cnt_q;
    logic            ovf_q;
    logic            fifo_empty, fifo_full, push, pop, xfer;
    logic [47:0]     head;

    logic [5:0]      hoff;
    logic [31:0]     fld;
    logic [7:0]      hdr_byte;

    // Past the 'BM' magic every field is 4-byte aligned at offset 2, so the
    // two 16-bit fields (planes, bpp) are handled as one 32-bit word.
    always_comb begin
        hoff = hdr_q - 6'd2;
        case (hoff[5:2])
            4'd0:       fld = FILE_SIZE;
            4'd2:       fld = 32'd54;
            4'd3:       fld = 32'd40;
            4'd4:       fld = 32'(WIDTH);
            4'd5:       fld = 32'(HEIGHT);
            4'd6:       fld = 32'h0018_0001;
            4'd8:       fld = IMG_SIZE;
            4'd9, 4'd10: fld = 32'd2835;
            default:    fld = 32'd0;
        endcase
        if (hdr_q == 6'd0)      hdr_byte = 8'h42;
        else if (hdr_q == 6'd1) hdr_byte = 8'h4D;
        else                    hdr_byte = fld[{hoff[1:0], 3'b000} +: 8];
    end

    always_comb begin
        head       = mem[rd_q];
        fifo_empty = (cnt_q == '0);
        fifo_full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
        byte_valid = 1'b0;
        byte_out   = 8'h00;
        case (state_q)
            S_HEADER: begin
                byte_valid = run_q;
                byte_out   = run_q ? hdr_byte : 8'h00;
            end
            S_PIXELS: begin
                byte_valid = !fifo_empty;
                byte_out   = fifo_empty ? 8'h00 : head[{byte_q, 3'b000} +: 8];
            end
            S_PAD:    byte_valid = 1'b1;
            default:  ;
        endcase
        xfer = byte_valid & byte_ready;
        pop  = (state_q == S_PIXELS) && xfer && (byte_q == 3'd5);
        push = hsync && (state_q != S_DONE) && (!fifo_full || pop);
    end

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        byte_d  = byte_q;
        pair_d  = pair_q;
        row_d   = row_q;
        pad_d   = pad_q;
        row_end = 1'b0;
        case (state_q)
            S_HEADER: if (xfer) begin
                if (hdr_q == 6'd53) begin
                    hdr_d   = 6'd0;
                    state_d = S_PIXELS;
                end else begin
                    hdr_d = hdr_q + 6'd1;
                end
            end
            S_PIXELS: if (xfer) begin
                if (byte_q == 3'd5) begin
                    byte_d = 3'd0;
                    if (pair_q == PW'(WIDTH / 2 - 1)) begin
                        pair_d = '0;
                        if (PAD > 0) state_d = S_PAD;
                        else         row_end = 1'b1;
                    end else begin
                        pair_d = pair_q + 1'b1;
                    end
                end else begin
                    byte_d = byte_q + 3'd1;
                end
            end
            S_PAD: if (xfer) begin
                if (pad_q == 2'(PAD - 1)) begin
                    pad_d   = 2'd0;
                    row_end = 1'b1;
                end else begin
                    pad_d = pad_q + 2'd1;
                end
            end
            default: ;
        endcase
        if (row_end) begin
            row_d   = row_q + 1'b1;
            state_d = (row_d == RW'(HEIGHT)) ? S_DONE : S_PIXELS;
        end
    end

    // run_q keeps the stream quiet while reset is held and for the release edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_HEADER;
            run_q   <= 1'b0;
            hdr_q   <= '0;
            byte_q  <= '0;
            pair_q  <= '0;
            row_q   <= '0;
            pad_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            hdr_q   <= hdr_d;
            byte_q  <= byte_d;
            pair_q  <= pair_d;
            row_q   <= row_d;
            pad_q   <= pad_d;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase
            if (hsync && (state_q != S_DONE) && fifo_full && !pop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (push) mem[wr_q] <= {DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1,
                                DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0};
    end

    assign overflow   = ovf_q;
    assign Write_Done = (state_q == S_DONE);

endmodule

// File: tb/tb_bmp_stream_writer.sv
// Self-checking bench for bmp_stream_writer: three parameterisations share
// one stimulus; each test compares the selected instance against a file model.
module tb_bmp_stream_writer;

    typedef struct packed {
        logic [7:0] r0, g0, b0, r1, g1, b1;
    } pix_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hsync = 1'b0;
    logic rdy = 1'b0;
    pix_t din = '0;

    always #5 clk = ~clk;

    logic [7:0] bo_a, bo_b, bo_c, bo;
    logic bv_a, bv_b, bv_c, bv;
    logic ovf_a, ovf_b, ovf_c, ovf;
    logic done_a, done_b, done_c, done;
    int sel = 0;

    bmp_stream_writer #(.WIDTH(6), .HEIGHT(2), .FIFO_DEPTH(16)) u_a (
        .HCLK(clk), .HRESETn(rst_n), .hsync(hsync),
        .DATA_WRITE_R0(din.r0), .DATA_WRITE_G0(din.g0), .DATA_WRITE_B0(din.b0),
        .DATA_WRITE_R1(din.r1), .DATA_WRITE_G1(din.g1), .DATA_WRITE_B1(din.b1),
        .byte_out(bo_a), .byte_valid(bv_a), .byte_ready(rdy),
        .overflow(ovf_a), .Write_Done(done_a));

    bmp_stream_writer #(.WIDTH(4), .HEIGHT(1), .FIFO_DEPTH(16)) u_b (
        .HCLK(clk), .HRESETn(rst_n), .hsync(hsync),
        .DATA_WRITE_R0(din.r0), .DATA_WRITE_G0(din.g0), .DATA_WRITE_B0(din.b0),
        .DATA_WRITE_R1(din.r1), .DATA_WRITE_G1(din.g1), .DATA_WRITE_B1(din.b1),
        .byte_out(bo_b), .byte_valid(bv_b), .byte_ready(rdy),
        .overflow(ovf_b), .Write_Done(done_b));

    bmp_stream_writer #(.WIDTH(6), .HEIGHT(2), .FIFO_DEPTH(2)) u_c (
        .HCLK(clk), .HRESETn(rst_n), .hsync(hsync),
        .DATA_WRITE_R0(din.r0), .DATA_WRITE_G0(din.g0), .DATA_WRITE_B0(din.b0),
        .DATA_WRITE_R1(din.r1), .DATA_WRITE_G1(din.g1), .DATA_WRITE_B1(din.b1),
        .byte_out(bo_c), .byte_valid(bv_c), .byte_ready(rdy),
        .overflow(ovf_c), .Write_Done(done_c));

    always_comb begin
        case (sel)
            0:       begin bo = bo_a; bv = bv_a; ovf = ovf_a; done = done_a; end
            1:       begin bo = bo_b; bv = bv_b; ovf = ovf_b; done = done_b; end
            default: begin bo = bo_c; bv = bv_c; ovf = ovf_c; done = done_c; end
        endcase
    end

    int errs = 0;
    int checks = 0;
    pix_t pairs[$];
    logic [7:0] exp_q[$];
    logic [7:0] cap[$];
    logic hold_prev = 1'b0;
    logic [7:0] hold_byte = 8'h00;

    task automatic chk(input string tag, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    function automatic pix_t rnd_pix();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return pix_t'(r[47:0]);
    endfunction

    task automatic put32(input int v);
        for (int i = 0; i < 4; i++) exp_q.push_back(v[8*i +: 8]);
    endtask

    // Whole-file model: header from the format rules, then rows of pairs in
    // arrival order; pairs not supplied are modelled as zero.
    task automatic build_exp(input int w, input int h);
        int pad, rowb, k;
        pix_t p;
        pad  = (4 - (3 * w) % 4) % 4;
        rowb = 3 * w + pad;
        exp_q.delete();
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h4D);
        put32(54 + h * rowb); put32(0); put32(54);
        put32(40); put32(w); put32(h);
        exp_q.push_back(8'd1);  exp_q.push_back(8'd0);
        exp_q.push_back(8'd24); exp_q.push_back(8'd0);
        put32(0); put32(h * rowb); put32(2835); put32(2835); put32(0); put32(0);
        k = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w / 2; c++) begin
                p = (k < pairs.size()) ? pairs[k] : '0;
                k++;
                exp_q.push_back(p.b0); exp_q.push_back(p.g0); exp_q.push_back(p.r0);
                exp_q.push_back(p.b1); exp_q.push_back(p.g1); exp_q.push_back(p.r1);
            end
            for (int i = 0; i < pad; i++) exp_q.push_back(8'h00);
        end
    endtask

    task automatic cmp_cap(input string nm, input int n);
        chk({nm, "_len"}, cap.size(), n);
        for (int i = 0; i < n && i < cap.size(); i++)
            chk($sformatf("%s_b%0d", nm, i), cap[i], exp_q[i]);
    endtask

    // One clock: sample at the falling edge, drive inputs for the next rising edge.
    task automatic step(input logic hs, input pix_t p, input logic r);
        @(negedge clk);
        if (hold_prev) begin
            chk("hold_valid", bv, 1);
            chk("hold_byte", bo, hold_byte);
        end
        hsync = hs;
        din   = p;
        rdy   = r;
        if (bv && r) cap.push_back(bo);
        hold_prev = bv && !r;
        hold_byte = bo;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        hsync = 1'b0;
        rdy   = 1'b0;
        hold_prev = 1'b0;
        cap.delete();
        repeat (2) @(negedge clk);
        chk("rst_valid", bv, 0);
        chk("rst_byte", bo, 0);
        chk("rst_overflow", ovf, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, pi;

        // Test 1: W6 H2, ready held high
        sel = 0;
        pairs.delete();
        for (int i = 0; i < 6; i++) pairs.push_back(rnd_pix());
        do_reset();
        step(1'b0, '0, 1'b1);
        chk("first_cycle_xfer", cap.size(), 1);
        cyc = 0; pi = 0;
        while (!done && cyc < 400) begin
            if (cyc >= 60 && pi < 6) begin step(1'b1, pairs[pi], 1'b1); pi++; end
            else step(1'b0, '0, 1'b1);
            cyc++;
        end
        chk("t1_done", done, 1);
        chk("t1_overflow", ovf, 0);
        build_exp(6, 2);
        cmp_cap("t1", 94);
        if (cap.size() >= 38) begin
            chk("t1_fsize0", cap[2], 8'h5E);  chk("t1_fsize1", cap[3], 8'h00);
            chk("t1_fsize2", cap[4], 8'h00);  chk("t1_fsize3", cap[5], 8'h00);
            chk("t1_img0", cap[34], 8'h28);   chk("t1_img1", cap[35], 8'h00);
        end

        // Test 2: same stream under random backpressure
        do_reset();
        cyc = 0; pi = 0;
        while (!done && cyc < 1500) begin
            if (cyc >= 60 && pi < 6) begin step(1'b1, pairs[pi], 1'($urandom_range(1, 0))); pi++; end
            else step(1'b0, '0, 1'($urandom_range(1, 0)));
            cyc++;
        end
        chk("t2_done", done, 1);
        chk("t2_overflow", ovf, 0);
        cmp_cap("t2", 94);

        // Test 3: depth-2 FIFO, three pairs while stalled -> third dropped
        sel = 2;
        pairs.delete();
        for (int i = 0; i < 3; i++) pairs.push_back(rnd_pix());
        do_reset();
        cyc = 0;
        while (cap.size() < 54 && cyc < 100) begin step(1'b0, '0, 1'b1); cyc++; end
        for (int i = 0; i < 3; i++) step(1'b1, pairs[i], 1'b0);
        step(1'b0, '0, 1'b0);
        chk("t3_overflow_set", ovf, 1);
        repeat (30) step(1'b0, '0, 1'b1);
        chk("t3_overflow_sticky", ovf, 1);
        chk("t3_bubble_valid", bv, 0);
        void'(pairs.pop_back());
        build_exp(6, 2);
        cmp_cap("t3", 66);

        // Test 4: depth-2 FIFO, every later push lands on a full FIFO at an R1 pop
        pairs.delete();
        for (int i = 0; i < 6; i++) pairs.push_back(rnd_pix());
        do_reset();
        cyc = 0; pi = 0;
        while (!done && cyc < 400) begin
            int j, r1;
            j  = pi - 2;
            r1 = 54 + (j / 3) * 20 + (j % 3) * 6 + 5;
            if (pi < 2 && cyc >= 10) begin step(1'b1, pairs[pi], 1'b1); pi++; end
            else if (pi >= 2 && pi < 6 && cap.size() == r1) begin step(1'b1, pairs[pi], 1'b1); pi++; end
            else step(1'b0, '0, 1'b1);
            cyc++;
        end
        chk("t4_pushes", pi, 6);
        chk("t4_done", done, 1);
        chk("t4_overflow", ovf, 0);
        build_exp(6, 2);
        cmp_cap("t4", 94);

        // Test 5: W4 H1, no padding; pairs after DONE ignored
        sel = 1;
        pairs.delete();
        for (int i = 0; i < 2; i++) pairs.push_back(rnd_pix());
        do_reset();
        cyc = 0; pi = 0;
        while (!done && cyc < 200) begin
            if (cyc >= 60 && pi < 2) begin step(1'b1, pairs[pi], 1'b1); pi++; end
            else step(1'b0, '0, 1'b1);
            cyc++;
        end
        build_exp(4, 1);
        cmp_cap("t5", 66);
        for (int i = 0; i < 20; i++) step(1'b1, rnd_pix(), 1'b1);
        step(1'b0, '0, 1'b1);
        chk("t5_overflow", ovf, 0);
        chk("t5_done", done, 1);
        chk("t5_valid", bv, 0);
        chk("t5_len_after", cap.size(), 66);

        // Test 6: reset in mid-row, stream restarts cleanly
        sel = 0;
        pairs.delete();
        for (int i = 0; i < 3; i++) pairs.push_back(rnd_pix());
        do_reset();
        cyc = 0; pi = 0;
        while (cap.size() < 59 && cyc < 200) begin
            if (cyc >= 60 && pi < 3) begin step(1'b1, pairs[pi], 1'b1); pi++; end
            else step(1'b0, '0, 1'b1);
            cyc++;
        end
        chk("t6_reached", cap.size(), 59);
        rst_n = 1'b0;
        hsync = 1'b0;
        #1;
        chk("t6_rst_valid", bv, 0);
        chk("t6_rst_byte", bo, 0);
        chk("t6_rst_overflow", ovf, 0);
        chk("t6_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        hold_prev = 1'b0;
        cap.delete();
        repeat (70) step(1'b0, '0, 1'b1);
        pairs.delete();
        build_exp(6, 2);
        cmp_cap("t6", 54);
        chk("t6_fifo_empty", bv, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/bmp_stream_writer.md
# bmp_stream_writer

Synthesizable receiving end of the image pixel-pair stream. Accepts two RGB pixels per `hsync`-qualified cycle, the same interface the image writer consumes, and serializes them into a complete 24-bit BMP byte stream: header, BGR pixel bytes and per-row padding. The stream leaves on a valid/ready byte interface toward a storage or UART sink. It sits downstream of the image reader/processing pipeline in place of the simulation-only file writer.

## Interface
- `WIDTH`, 768: image width in pixels; must be even and ≥ 2.
- `HEIGHT`, 512: image height in rows; must be ≥ 1.
- `FIFO_DEPTH`, 16: pixel-pair FIFO entries; power of two, ≥ 2.
- `HCLK` in 1: single clock, rising edge.
- `HRESETn` in 1: reset, asynchronous and active-low.
- `hsync` in 1: pixel pair valid this cycle.
- `DATA_WRITE_R0`, `DATA_WRITE_G0`, `DATA_WRITE_B0` in 8 each: even (first) pixel.
- `DATA_WRITE_R1`, `DATA_WRITE_G1`, `DATA_WRITE_B1` in 8 each: odd (second) pixel.
- `byte_out` out 8: BMP stream byte.
- `byte_valid` out 1: `byte_out` valid.
- `byte_ready` in 1: sink accepts byte.
- `overflow` out 1: sticky; a pair was dropped on a full FIFO.
- `Write_Done` out 1: sticky; the whole file has been transferred.

## Operation
- Derived values: `PAD = (4 - (3*WIDTH mod 4)) mod 4`. `ROWB = 3*WIDTH + PAD`. `FSIZE = 54 + HEIGHT*ROWB`. All header fields are little-endian.
- Header, 54 bytes, in this order:
  - 'B' (0x42), 'M' (0x4D)
  - FSIZE (4 bytes), 0 (4 bytes), 54 (4 bytes)
  - 40 (4), WIDTH (4), HEIGHT (4), 1 (2), 24 (2), 0 (4)
  - HEIGHT*ROWB (4), 2835 (4), 2835 (4), 0 (4), 0 (4)
- Input side:
  - On each edge with `hsync`=1 and state ≠ DONE, the 48-bit pair is pushed into the FIFO.
  - If the FIFO is full and no pop occurs that same edge, the pair is dropped and `overflow` sets.
  - Push on full coincident with a pop is accepted.
  - In DONE, input pairs are ignored and `overflow` is not set.
- FSM states:
  - HEADER: emit header bytes 0..53; after byte 53 transfers → PIXELS.
  - PIXELS: while the FIFO is non-empty, emit B0, G0, R0, B1, G1, R1 of the head entry. Pop on transfer of R1. After pair WIDTH/2 of a row → PAD if PAD>0, else row-end handling.
  - PAD: emit PAD bytes of 0x00. Then row-end handling.
  - Row-end handling: row counter +1; if it equals HEIGHT → DONE, else → PIXELS.
  - DONE: `byte_valid`=0 and `Write_Done`=1 until reset.
- Rows are emitted in arrival order; upstream delivers rows in BMP storage order (bottom row first).
- Counters:
  - Byte-in-pair counter, 0..5.
  - Pair-in-row counter, 0..WIDTH/2-1.
  - Row counter, 0..HEIGHT-1, sized `$clog2(HEIGHT+1)`.
  - Header index, 0..53.
  - All wrap only through the explicit transitions above.

## Timing
- Reset values:
  - `byte_valid`=0, `byte_out`=0x00, `overflow`=0, `Write_Done`=0.
  - FIFO empty, all counters 0, state HEADER.
- Reset asserted mid-operation aborts the file: all state returns to the reset values and the header restarts at byte 0 after release.
- First cycle after reset release: `byte_valid`=1 with `byte_out`=0x42.
- Transfer occurs on an edge with `byte_valid`&`byte_ready`.
- While `byte_valid`=1 and `byte_ready`=0, `byte_out` is held stable and `byte_valid` is not deasserted.
- With `byte_ready` held at 1, one byte transfers per cycle; the header takes exactly 54 cycles.
- Pixel latency: a pair pushed at edge N into an empty FIFO while in PIXELS appears as B0 with `byte_valid`=1 in the cycle after edge N.
- In PIXELS with the FIFO empty, `byte_valid`=0 (bubble); PAD bytes never wait on the FIFO.
- `Write_Done` rises in the cycle after the final byte transfers.

## Test plan
- WIDTH=6, HEIGHT=2, `byte_ready`=1; reset, then 6 pairs (one per cycle, starting 60 cycles after reset) → 94 bytes total.
  - Header bytes 2..5 = 5E 00 00 00; bytes 34..37 = 28 00 00 00.
  - Each row is 18 pixel bytes in BGR-pair order followed by 00 00.
  - `Write_Done`=1 after byte 93; `overflow`=0.
- Backpressure: `byte_ready` toggled pseudo-randomly → byte sequence identical to the previous test; `byte_out` never changes while valid & !ready.
- FIFO_DEPTH=2, `byte_ready`=0 during 3 consecutive `hsync` cycles in PIXELS → the 3rd pair is dropped, `overflow`=1 sticky, and the output carries only the first 2 pairs.
- Push on full with a coincident pop (R1 transfer) → pair accepted, `overflow` stays 0.
- WIDTH=4, HEIGHT=1 → PAD=0, file is 66 bytes with no zero padding; an extra `hsync` pair after DONE is ignored and `overflow` stays 0.
- Reset asserted mid-row (after header plus 5 pixel bytes) → all outputs return to reset values immediately; after release the stream restarts with 0x42 0x4D and the FIFO is empty.
